// File: rtl/noc_tg_pkg.sv
// Shared types, field-width helpers and LFSR taps for the mesh NoC traffic node.
package noc_tg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } tg_state_e;

  localparam logic MODE_FIXED  = 1'b0;
  localparam logic MODE_RANDOM = 1'b1;

  // Fibonacci taps at bits 0,2,3,5 realise x^16+x^14+x^13+x^11+1 for a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_w(input int row_n);
    return idx_w(row_n);
  endfunction

  function automatic int col_w(input int col_m);
    return idx_w(col_m);
  endfunction

  function automatic int node_w(input int row_n, input int col_m);
    return idx_w(row_n * col_m);
  endfunction

  function automatic int packet_w(input int data_w, input int row_n, input int col_m);
    return data_w + row_w(row_n) + col_w(col_m);
  endfunction

endpackage

// File: rtl/noc_tg_lfsr.sv
// 16-bit Fibonacci LFSR with seed load on reset and advance enable.
module noc_tg_lfsr
  import noc_tg_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  output logic [15:0] lfsr_o,
  output logic [15:0] lfsr_nxt_o
);

  logic [15:0] lfsr_q;

  assign lfsr_nxt_o = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
  assign lfsr_o     = lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else if (adv_i) begin
      lfsr_q <= lfsr_nxt_o;
    end
  end

endmodule

// File: rtl/mesh_noc_traffic_node.sv
// Per-node traffic generator and in-order checker for the XY mesh resource port.
// Define NOC_TG_CHECK_EN to build the receive checker and expected-seq table.
//
// state | meaning
// IDLE  | after reset, waiting for start_i
// SEND  | presenting a packet, injected when the router is not full
// GAP   | counting idle cycles between injections
// DONE  | run complete, waiting for start_i
module mesh_noc_traffic_node
  import noc_tg_pkg::*;
#(
  parameter int          ROW_N       = 3,
  parameter int          COL_M       = 3,
  parameter int          PCKT_DATA_W = 8,
  parameter int          ROW_IDX     = 0,
  parameter int          COL_IDX     = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         ROW_W       = row_w(ROW_N),
  localparam int         COL_W       = col_w(COL_M),
  localparam int         PACKET_W    = packet_w(PCKT_DATA_W, ROW_N, COL_M)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                cfg_mode_i,
  input  logic [ROW_W-1:0]    cfg_dst_row_i,
  input  logic [COL_W-1:0]    cfg_dst_col_i,
  input  logic [15:0]         cfg_pckt_cnt_i,
  input  logic [7:0]          cfg_gap_i,
  output logic [PACKET_W-1:0] rsc_pckt_o,
  output logic                rsc_wren_o,
  input  logic                noc_full_i,
  input  logic                noc_ovrflw_i,
  input  logic [PACKET_W-1:0] noc_pckt_i,
  input  logic                noc_wren_i,
  output logic                rsc_full_o,
  output logic                rsc_ovrflw_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         tx_cnt_o,
  output logic [15:0]         rx_cnt_o,
  output logic [15:0]         err_cnt_o,
  output logic                ovrflw_seen_o
);

  localparam int NODE_W = node_w(ROW_N, COL_M);
  localparam int SEQ_W  = PCKT_DATA_W - NODE_W;
  localparam logic [NODE_W-1:0] MY_ID   = NODE_W'(ROW_IDX * COL_M + COL_IDX);
  localparam logic [ROW_W:0]    ROW_LIM = (ROW_W + 1)'(ROW_N);
  localparam logic [COL_W:0]    COL_LIM = (COL_W + 1)'(COL_M);

  tg_state_e state_q, state_nxt;
  logic start_go, accept, last_pckt;

  logic             mode_q;
  logic [ROW_W-1:0] dst_row_q;
  logic [COL_W-1:0] dst_col_q;
  logic [15:0]      pckt_cnt_q;
  logic [7:0]       gap_q, gap_cnt_q;
  logic [SEQ_W-1:0] seq_q, seq_sel;
  logic [15:0]      tx_cnt_q, rx_cnt_q;
  logic             ovrflw_q, busy_q, done_q;
  logic [PACKET_W-1:0] pckt_q;

  logic [15:0]      lfsr_cur, lfsr_nxt, lfsr_sel;
  logic             mode_sel;
  logic [ROW_W-1:0] rnd_row, dst_row_sel;
  logic [COL_W-1:0] rnd_col, dst_col_sel;
  logic             unused_lfsr_hi;

  noc_tg_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .adv_i     (accept),
    .lfsr_o    (lfsr_cur),
    .lfsr_nxt_o(lfsr_nxt)
  );

  assign last_pckt = (tx_cnt_q + 16'd1) == pckt_cnt_q;

  always_comb begin
    state_nxt  = state_q;
    start_go   = 1'b0;
    accept     = 1'b0;
    rsc_wren_o = (state_q == ST_SEND) & ~noc_full_i;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          start_go  = 1'b1;
          state_nxt = (cfg_pckt_cnt_i == 16'd0) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (!noc_full_i) begin
          accept = 1'b1;
          if (last_pckt)           state_nxt = ST_DONE;
          else if (gap_q != 8'd0)  state_nxt = ST_GAP;
          else                     state_nxt = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) state_nxt = ST_SEND;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // At start the packet uses the live LFSR; after an acceptance it uses the advanced value.
  always_comb begin
    mode_sel = start_go ? cfg_mode_i : mode_q;
    lfsr_sel = start_go ? lfsr_cur : lfsr_nxt;
    rnd_row  = lfsr_sel[ROW_W-1:0];
    rnd_col  = lfsr_sel[ROW_W+COL_W-1:ROW_W];
    if ({1'b0, rnd_row} >= ROW_LIM) rnd_row = rnd_row - ROW_LIM[ROW_W-1:0];
    if ({1'b0, rnd_col} >= COL_LIM) rnd_col = rnd_col - COL_LIM[COL_W-1:0];
    dst_row_sel = rnd_row;
    dst_col_sel = rnd_col;
    unique case (mode_sel)
      MODE_FIXED: begin
        dst_row_sel = start_go ? cfg_dst_row_i : dst_row_q;
        dst_col_sel = start_go ? cfg_dst_col_i : dst_col_q;
      end
      MODE_RANDOM: begin
        dst_row_sel = rnd_row;
        dst_col_sel = rnd_col;
      end
      default: ;
    endcase
    seq_sel = start_go ? '0 : seq_q + SEQ_W'(1);
  end

  assign unused_lfsr_hi = ^lfsr_sel[15:ROW_W+COL_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= (state_nxt == ST_SEND) || (state_nxt == ST_GAP);
      done_q  <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= MODE_FIXED;
      dst_row_q  <= '0;
      dst_col_q  <= '0;
      pckt_cnt_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      seq_q      <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      ovrflw_q   <= 1'b0;
      pckt_q     <= '0;
    end else begin
      if (start_go) begin
        mode_q     <= cfg_mode_i;
        dst_row_q  <= cfg_dst_row_i;
        dst_col_q  <= cfg_dst_col_i;
        pckt_cnt_q <= cfg_pckt_cnt_i;
        gap_q      <= cfg_gap_i;
        seq_q      <= '0;
        tx_cnt_q   <= '0;
        pckt_q     <= {dst_row_sel, dst_col_sel, MY_ID, seq_sel};
      end else if (accept) begin
        seq_q     <= seq_sel;
        gap_cnt_q <= gap_q - 8'd1;
        pckt_q    <= {dst_row_sel, dst_col_sel, MY_ID, seq_sel};
        if (tx_cnt_q != 16'hFFFF) tx_cnt_q <= tx_cnt_q + 16'd1;
      end else if (state_q == ST_GAP && gap_cnt_q != 8'd0) begin
        gap_cnt_q <= gap_cnt_q - 8'd1;
      end

      if (start_go)                             rx_cnt_q <= '0;
      else if (noc_wren_i && rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;

      // An overflow in the same cycle as start must not be lost.
      if (noc_ovrflw_i)  ovrflw_q <= 1'b1;
      else if (start_go) ovrflw_q <= 1'b0;
    end
  end

`ifdef NOC_TG_CHECK_EN
  localparam logic [ROW_W-1:0] MY_ROW   = ROW_W'(ROW_IDX);
  localparam logic [COL_W-1:0] MY_COL   = COL_W'(COL_IDX);
  localparam logic [NODE_W:0]  NODE_LIM = (NODE_W + 1)'(ROW_N * COL_M);

  logic [ROW_W-1:0]  rx_row;
  logic [COL_W-1:0]  rx_col;
  logic [NODE_W-1:0] rx_src;
  logic [SEQ_W-1:0]  rx_seq;
  logic              rx_src_ok, rx_err;
  logic [SEQ_W-1:0]  exp_q [2**NODE_W];
  logic [15:0]       err_cnt_q;

  assign rx_row    = noc_pckt_i[PACKET_W-1 -: ROW_W];
  assign rx_col    = noc_pckt_i[PCKT_DATA_W+COL_W-1 -: COL_W];
  assign rx_src    = noc_pckt_i[PCKT_DATA_W-1 -: NODE_W];
  assign rx_seq    = noc_pckt_i[SEQ_W-1:0];
  assign rx_src_ok = {1'b0, rx_src} < NODE_LIM;
  assign rx_err    = (rx_row != MY_ROW) || (rx_col != MY_COL) || !rx_src_ok ||
                     (rx_seq != exp_q[rx_src]);

  // The table follows the last seq seen so one lost packet costs a single error.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_go) begin
      for (int i = 0; i < 2**NODE_W; i++) exp_q[i] <= '0;
      err_cnt_q <= '0;
    end else if (noc_wren_i) begin
      if (rx_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      if (rx_src_ok) exp_q[rx_src] <= rx_seq + SEQ_W'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_rx_pckt;
  assign unused_rx_pckt = ^noc_pckt_i;
  assign err_cnt_o      = '0;
`endif

  assign rsc_pckt_o    = pckt_q;
  assign rsc_full_o    = 1'b0;
  assign rsc_ovrflw_o  = 1'b0;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign tx_cnt_o      = tx_cnt_q;
  assign rx_cnt_o      = rx_cnt_q;
  assign ovrflw_seen_o = ovrflw_q;

endmodule

// File: tb/tb_mesh_noc_traffic_node.sv
// Self-checking bench for mesh_noc_traffic_node on a 3x3 mesh, node (0,0).
module tb_mesh_noc_traffic_node;

  localparam int PW = 12;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef NOC_TG_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, start = 1'b0, cfg_mode = 1'b0;
  logic [1:0]    cfg_row = '0, cfg_col = '0;
  logic [15:0]   cfg_cnt = '0;
  logic [7:0]    cfg_gap = '0;
  logic          noc_full = 1'b0, noc_ovr = 1'b0, inj_wren = 1'b0, loopback = 1'b0;
  logic [PW-1:0] inj_pckt = '0;

  logic [PW-1:0] rsc_pckt, noc_pckt;
  logic          rsc_wren, noc_wren, rsc_full, rsc_ovr, busy, done, ovr_seen;
  logic [15:0]   tx_cnt, rx_cnt, err_cnt;

  assign noc_pckt = loopback ? rsc_pckt : inj_pckt;
  assign noc_wren = loopback ? rsc_wren : inj_wren;

  mesh_noc_traffic_node dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_mode_i(cfg_mode),
    .cfg_dst_row_i(cfg_row), .cfg_dst_col_i(cfg_col), .cfg_pckt_cnt_i(cfg_cnt),
    .cfg_gap_i(cfg_gap), .rsc_pckt_o(rsc_pckt), .rsc_wren_o(rsc_wren),
    .noc_full_i(noc_full), .noc_ovrflw_i(noc_ovr), .noc_pckt_i(noc_pckt),
    .noc_wren_i(noc_wren), .rsc_full_o(rsc_full), .rsc_ovrflw_o(rsc_ovr),
    .busy_o(busy), .done_o(done), .tx_cnt_o(tx_cnt), .rx_cnt_o(rx_cnt),
    .err_cnt_o(err_cnt), .ovrflw_seen_o(ovr_seen)
  );

  int total = 0, bad = 0, cyc = 0, rng_bad = 0;
  logic [PW-1:0] sb_q[$];
  int wr_t[$];
  logic [15:0] lfsr_m = SEED;

  typedef struct {
    logic [PW-1:0] pckt;
    logic          wren;
    logic          ovr;
    logic [15:0]   err;
    logic [15:0]   rx;
    logic          ovr_seen;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int r, input int c, input int src, input int seq);
    return {2'(r), 2'(c), 4'(src), 4'(seq)};
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  function automatic int red3(input logic [1:0] v);
    return (v >= 2'd3) ? int'(v) - 3 : int'(v);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && rsc_wren) begin
      wr_t.push_back(cyc);
      if (rsc_pckt[11:10] >= 2'd3 || rsc_pckt[9:8] >= 2'd3) rng_bad++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected: got %0h want no injection", rsc_pckt);
      end else begin
        check("tx_pckt", rsc_pckt, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic mode, input int r, input int c, input int cnt, input int gap);
    logic [15:0] l;
    tick();
    cfg_mode = mode;
    cfg_row  = 2'(r);
    cfg_col  = 2'(c);
    cfg_cnt  = 16'(cnt);
    cfg_gap  = 8'(gap);
    start    = 1'b1;
    l = lfsr_m;
    for (int k = 0; k < cnt; k++) begin
      sb_q.push_back(mk(mode ? red3(l[1:0]) : r, mode ? red3(l[3:2]) : c, 0, k));
      l = lstep(l);
    end
    lfsr_m = l;
    wr_t.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_reached", done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, busy_drop, hold_wr, hold_pk;

    vecs[0] = '{mk(1,0,0,0), 1'b1, 1'b0, 16'd1, 16'd1, 1'b0};
    vecs[1] = '{mk(0,0,4,0), 1'b1, 1'b0, 16'd1, 16'd2, 1'b0};
    vecs[2] = '{mk(0,0,4,1), 1'b1, 1'b0, 16'd1, 16'd3, 1'b0};
    vecs[3] = '{mk(0,0,4,3), 1'b1, 1'b0, 16'd2, 16'd4, 1'b0};
    vecs[4] = '{mk(0,0,4,4), 1'b1, 1'b0, 16'd2, 16'd5, 1'b0};
    vecs[5] = '{mk(0,0,9,0), 1'b1, 1'b0, 16'd3, 16'd6, 1'b0};
    vecs[6] = '{mk(2,2,7,7), 1'b0, 1'b0, 16'd3, 16'd6, 1'b0};
    vecs[7] = '{mk(0,0,0,1), 1'b1, 1'b0, 16'd3, 16'd7, 1'b0};
    vecs[8] = '{12'h000,     1'b0, 1'b1, 16'd3, 16'd7, 1'b1};
    vecs[9] = '{mk(0,0,4,5), 1'b1, 1'b0, 16'd3, 16'd8, 1'b1};

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wren", rsc_wren, 0);
    check("rst_pckt", rsc_pckt, 0);
    check("rst_tx", tx_cnt, 0);
    check("rst_rx", rx_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_ovr", ovr_seen, 0);
    check("rst_full", rsc_full, 0);
    check("rst_rsc_ovr", rsc_ovr, 0);
    rst = 1'b0;

    // loopback, fixed (0,0), 5 packets back to back
    loopback = 1'b1;
    start_run(1'b0, 0, 0, 5, 0);
    wait_done(50);
    check("b2b_tx", tx_cnt, 5);
    check("b2b_rx", rx_cnt, 5);
    check("b2b_err", err_cnt, 0);
    check("b2b_busy", busy, 0);
    check("b2b_sb", sb_q.size(), 0);
    check("b2b_n", wr_t.size(), 5);
    for (int i = 1; i < wr_t.size(); i++) check("b2b_int", wr_t[i] - wr_t[i-1], 1);

    // gap 3, 4 packets
    start_run(1'b0, 0, 0, 4, 3);
    busy_drop = 0;
    n = 0;
    while (!done && n < 100) begin
      if (!busy) busy_drop++;
      tick();
      n++;
    end
    check("gap_done", done, 1);
    check("gap_busy_drop", busy_drop, 0);
    check("gap_n", wr_t.size(), 4);
    for (int i = 1; i < wr_t.size(); i++) check("gap_int", wr_t[i] - wr_t[i-1], 4);
    check("gap_tx", tx_cnt, 4);
    check("gap_rx", rx_cnt, 4);
    check("gap_err", err_cnt, 0);

    // router full for 10 cycles after the 2nd packet
    start_run(1'b0, 0, 0, 5, 0);
    n = 0;
    while (tx_cnt != 16'd2 && n < 50) begin
      tick();
      n++;
    end
    check("hold_reach", tx_cnt, 2);
    noc_full = 1'b1;
    hold_wr = 0;
    hold_pk = 0;
    repeat (10) begin
      #1;
      if (rsc_wren) hold_wr++;
      if (rsc_pckt !== mk(0,0,0,2)) hold_pk++;
      tick();
    end
    noc_full = 1'b0;
    check("hold_wren", hold_wr, 0);
    check("hold_pckt", hold_pk, 0);
    wait_done(50);
    check("hold_tx", tx_cnt, 5);
    check("hold_rx", rx_cnt, 5);
    check("hold_sb", sb_q.size(), 0);

    // receive checker, driven directly on the ejection port
    loopback = 1'b0;
    start_run(1'b0, 0, 0, 0, 0);
    check("zero_done", done, 1);
    check("zero_rx", rx_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      inj_pckt = vecs[i].pckt;
      inj_wren = vecs[i].wren;
      noc_ovr  = vecs[i].ovr;
      tick();
      check("vec_err", err_cnt, CHK ? 32'(vecs[i].err) : 32'd0);
      check("vec_rx", rx_cnt, vecs[i].rx);
      check("vec_ovr", ovr_seen, vecs[i].ovr_seen);
    end
    inj_wren = 1'b0;
    noc_ovr  = 1'b0;

    // random destinations, 100 packets
    rng_bad = 0;
    start_run(1'b1, 0, 0, 100, 0);
    wait_done(300);
    check("rnd_tx", tx_cnt, 100);
    check("rnd_rx", rx_cnt, 0);
    check("rnd_sb", sb_q.size(), 0);
    check("rnd_range", rng_bad, 0);
    check("rnd_ovr_clr", ovr_seen, 0);

    // reset in the middle of a run
    loopback = 1'b1;
    start_run(1'b0, 0, 0, 20, 0);
    repeat (3) tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_wren", rsc_wren, 0);
    check("mr_pckt", rsc_pckt, 0);
    check("mr_tx", tx_cnt, 0);
    check("mr_rx", rx_cnt, 0);
    check("mr_err", err_cnt, 0);
    rst = 1'b0;
    sb_q.delete();
    lfsr_m = SEED;
    start_run(1'b0, 0, 0, 3, 0);
    wait_done(50);
    check("post_tx", tx_cnt, 3);
    check("post_rx", rx_cnt, 3);
    check("post_err", err_cnt, 0);
    check("post_sb", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
